// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the 8-bit microcontroller datapath.
// Sequences each instruction as FETCH then EXEC, with start/step/halt control.
module uc_multiciclo #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   input  logic             start,
   input  logic             step_mode,
   output logic [2:0]       Op,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic             pc_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] grp;
   logic       is_halt;
   logic       unused_op_lo;

   assign grp          = Opcode[5:2];
   assign is_halt      = (grp == 4'b1111);
   assign unused_op_lo = ^Opcode[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_FETCH;
         S_FETCH: state_nx = S_EXEC;
         S_EXEC: begin
            if (is_halt)        state_nx = S_HALT;
            else if (step_mode) state_nx = S_IDLE;
            else                state_nx = S_FETCH;
         end
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   // Control decode is only live in EXEC; every other state is all-zero.
   always_comb begin
      Op    = 3'b000;
      s_inc = 1'b0;
      s_inm = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      pc_en = 1'b0;
      if (state == S_EXEC) begin
         unique case (1'b1)
            !grp[3]: begin
               Op    = grp[2:0];
               we3   = 1'b1;
               wez   = 1'b1;
               s_inc = 1'b1;
               pc_en = 1'b1;
            end
            (grp == 4'b1000): begin
               s_inm = 1'b1;
               we3   = 1'b1;
               s_inc = 1'b1;
               pc_en = 1'b1;
            end
            (grp[3:2] == 2'b10 && grp[1:0] != 2'b00): begin
               s_inc = 1'b1;
               pc_en = 1'b1;
            end
            (grp == 4'b1100): pc_en = 1'b1;
            (grp == 4'b1101): begin
               s_inc = ~z;
               pc_en = 1'b1;
            end
            (grp == 4'b1110): begin
               s_inc = z;
               pc_en = 1'b1;
            end
            is_halt: pc_en = 1'b0;
            default: pc_en = 1'b0;
         endcase
      end
   end

   always_comb begin
      running = (state == S_FETCH) || (state == S_EXEC);
      halted  = (state == S_HALT);
   end

   // Saturating retire counter; HALT retires too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_count <= '0;
      end else if (state == S_EXEC && instr_count != {CNT_W{1'b1}}) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
